shift_sequencer: RTL and testbench

- Multi-cycle barrel-shift controller for the 16-bit datapath.
- Executes a shift of 0..15 positions by iterating a single-position shift step once per clock, using the datapath shift encoding (00 pass, 01 LSL, 10 LSR, 11 ASR).
- Sits between the instruction controller and the ALU B-operand path.
- Reports result, carry-out and zero flag through a start/done handshake.

---
 rtl/shift_sequencer.sv | 136 +++++++++++++
 tb/tb_shift_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies one single-position shift per clock for 0..2^CW-1 steps
// and reports result, last carry-out and zero flag through a start/done handshake.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  input  logic [CW-1:0]    amount,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [1:0]    OP_PASS = 2'b00;
  localparam logic [1:0]    OP_LSL  = 2'b01;
  localparam logic [1:0]    OP_LSR  = 2'b10;
  localparam logic [1:0]    OP_ASR  = 2'b11;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH:0]   step_s;

  // Unrecognised (including X) encodings collapse to pass-through.
  function automatic logic [1:0] op_clean(input logic [1:0] o);
    logic [1:0] r;
    case (o)
      OP_LSL:  r = OP_LSL;
      OP_LSR:  r = OP_LSR;
      OP_ASR:  r = OP_ASR;
      default: r = OP_PASS;
    endcase
    return r;
  endfunction

  // Returns {bit shifted out, shifted value} for one position.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] o, input logic [WIDTH-1:0] r);
    logic [WIDTH:0] s;
    case (o)
      OP_LSL:  s = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
      OP_LSR:  s = {r[0], 1'b0, r[WIDTH-1:1]};
      OP_ASR:  s = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
      default: s = {1'b0, r};
    endcase
    return s;
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    count_d  = count_q;
    op_d     = op_q;
    step_s   = shift_step(op_q, result_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = value;
          carry_d  = 1'b0;
          count_d  = amount;
          op_d     = op_clean(op);
          if ((amount != {CW{1'b0}}) && (op_clean(op) != OP_PASS)) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          result_d = step_s[WIDTH-1:0];
          carry_d  = step_s[WIDTH];
          count_d  = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      count_q  <= {CW{1'b0}};
      op_q     <= OP_PASS;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == SHIFT) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes model results, a monitor
// pops and compares them whenever done is presented.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] value;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  shift_sequencer #(.WIDTH(16), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .value(value), .op(op), .amount(amount),
    .ready(ready), .busy(busy), .done(done),
    .result(result), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit op_known(input logic [1:0] o);
    case (o)
      2'b01, 2'b10, 2'b11: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Closed-form result of shifting v by n positions.
  function automatic exp_t model(input logic [15:0] v, input logic [1:0] o, input int n);
    exp_t e;
    e.r = v;
    e.c = 1'b0;
    e.cyc = 0;
    if (op_known(o) && n > 0) begin
      case (o)
        2'b01: begin e.r = v << n; e.c = v[16-n]; end
        2'b10: begin e.r = v >> n; e.c = v[n-1]; end
        default: begin e.r = 16'($signed(v) >>> n); e.c = v[n-1]; end
      endcase
    end
    e.z = (e.r == 16'h0000);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.r));
        chk("carry", 32'(carry), 32'(mon_e.c));
        chk("zero", 32'(zero), 32'(mon_e.z));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("ready_low_in_done", 32'(ready), 32'd0);
      end
    end
  end

  task automatic run_op(input logic [15:0] v, input logic [1:0] o, input int a,
                        input bit ign, input int ab);
    int          neff;
    int          t;
    bit          seen;
    exp_t        e;
    logic [31:0] rnd;
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
    value = v; op = o; amount = a[3:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    neff = op_known(o) ? a : 0;
    if (ab < 0) begin
      e = model(v, o, a);
      e.cyc = cyc + neff;
      sb.push_back(e);
    end
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (ign) begin
      @(negedge clk);
      rnd = $urandom;
      value = ~v; op = rnd[1:0]; amount = rnd[5:2]; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    if (ab >= 0) begin
      repeat (ab) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      e = model(v, o, ab);
      chk("abort_result", 32'(result), 32'(e.r));
      chk("abort_carry", 32'(carry), 32'(e.c));
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_no_done", 32'(done), 32'd0);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (done) seen = 1'b1;
        else @(negedge clk);
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (seen) begin
        rnd = $urandom;
        value = rnd[15:0]; op = 2'b01; amount = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("done_single_cycle", 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rv;
    int          ra;
    int          rab;
    logic [1:0]  ro;
    bit          rign;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    value = 16'h0000; op = 2'b00; amount = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    run_op(16'h0001, 2'b01, 4, 1'b0, -1);
    run_op(16'h8000, 2'b11, 3, 1'b0, -1);
    run_op(16'h0003, 2'b10, 1, 1'b0, -1);
    run_op(16'hFFFF, 2'b01, 15, 1'b0, -1);
    run_op(16'hFFFF, 2'b10, 15, 1'b0, -1);
    run_op(16'h8001, 2'b11, 15, 1'b0, -1);
    run_op(16'hFFFF, 2'b00, 9, 1'b0, -1);
    run_op(16'h1234, 2'b10, 6, 1'b1, -1);
    run_op(16'h00F0, 2'b10, 8, 1'b0, 2);
    run_op(16'h5A5A, 2'bxx, 5, 1'b0, -1);
    run_op(16'h0000, 2'b01, 0, 1'b0, -1);

    // Asynchronous reset in the middle of a shift.
    value = 16'hA5A5; op = 2'b01; amount = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_zero", 32'(zero), 32'd1);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      rv = $urandom;
      ro = rv[17:16];
      ra = $urandom_range(0, 15);
      rab = -1;
      rign = 1'b0;
      if (ro != 2'b00 && ra > 1 && $urandom_range(0, 3) == 0) rab = $urandom_range(0, ra - 1);
      else if (ro != 2'b00 && ra >= 6) rign = rv[20];
      run_op(rv[15:0], ro, ra, rign, rab);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
